// File: rtl/bg_pkg.sv
// Shared constants, tile type codes and power-on row layout for the tiled
// 640x480 background scheduler.
package bg_pkg;

  localparam int unsigned BG_ROWS     = 15;
  localparam int unsigned BG_COLS     = 20;
  localparam int unsigned BG_H_START  = 144;
  localparam int unsigned BG_V_START  = 35;
  localparam int unsigned BG_H_TOTAL  = 800;
  localparam int unsigned BG_V_TOTAL  = 525;
  localparam int unsigned TILE_W      = 32;
  localparam int unsigned BG_H_ACTIVE = BG_COLS * TILE_W;

  typedef enum logic [2:0] {
    TT_DOUBLE  = 3'd0,
    TT_ONEWAY  = 3'd1,
    TT_ROAD    = 3'd2,
    TT_REVERSE = 3'd3,
    TT_MONO    = 3'd4,
    TT_RSVD5   = 3'd5,
    TT_RSVD6   = 3'd6,
    TT_NONE    = 3'd7
  } tile_type_e;

  typedef enum logic {
    ST_RUN,
    ST_COMMIT
  } sched_state_e;

  function automatic tile_type_e reset_type(input int unsigned row);
    case (row)
      0:       return TT_MONO;
      1:       return TT_REVERSE;
      6, 9:    return TT_DOUBLE;
      14:      return TT_ONEWAY;
      default: return TT_ROAD;
    endcase
  endfunction

  // Reserved codes render as black.
  function automatic logic [2:0] visible_type(input logic [2:0] t);
    return ((t == TT_RSVD5) || (t == TT_RSVD6)) ? TT_NONE : t;
  endfunction

endpackage

// File: rtl/bg_scroll_wrap.sv
// Signed mod-WRAP add of a per-row scroll speed onto its offset, shared by the
// serial commit loop. Only exists when BG_SCROLL_EN is defined.
`ifdef BG_SCROLL_EN
module bg_scroll_wrap #(
  parameter int unsigned WRAP = 640
) (
  input  logic [9:0] offset_i,
  input  logic [4:0] speed_i,
  output logic [9:0] wrapped_o
);

  logic [11:0] sum;

  always_comb begin
    sum       = {2'b00, offset_i} + {{7{speed_i[4]}}, speed_i};
    wrapped_o = sum[9:0];
    if (sum[11]) begin
      wrapped_o = 10'(sum + 12'(WRAP));
    end else if (sum >= 12'(WRAP)) begin
      wrapped_o = 10'(sum - 12'(WRAP));
    end
  end

endmodule
`endif

// File: rtl/bg_tile_scheduler.sv
// Per-pixel background tile scheduler: live/shadow row tables, config port and
// a once-per-frame serial commit in blanking. BG_SCROLL_EN adds per-row scroll.
module bg_tile_scheduler
  import bg_pkg::*;
#(
  parameter int unsigned ROWS    = BG_ROWS,
  parameter int unsigned COLS    = BG_COLS,
  parameter int unsigned H_START = BG_H_START,
  parameter int unsigned V_START = BG_V_START,
  parameter int unsigned H_TOTAL = BG_H_TOTAL,
  parameter int unsigned V_TOTAL = BG_V_TOTAL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_row,
  input  logic [2:0] cfg_type,
  input  logic [4:0] cfg_speed,
  output logic [2:0] tile_type,
  output logic [4:0] tile_x,
  output logic [4:0] tile_y,
  output logic [3:0] grid_row,
  output logic       active,
  output logic       frame_tick,
  output logic       cfg_err
);

  localparam int unsigned H_ACT = COLS * TILE_W;
  localparam int unsigned V_ACT = ROWS * TILE_W;

  sched_state_e state_q;
  logic [3:0]   idx_q;
  logic         cfg_ready_q;
  logic         frame_tick_q;
  logic         cfg_err_q;
  logic [2:0]   live_q   [ROWS];
  logic [2:0]   shadow_q [ROWS];

  logic         active_q;
  logic [2:0]   tile_type_q;
  logic [4:0]   tile_x_q;
  logic [4:0]   tile_y_q;
  logic [3:0]   grid_row_q;

  logic [9:0]   ah;
  logic [9:0]   av;
  logic         pix_active;
  logic [3:0]   pix_row;
  logic         row_ok;
  logic [2:0]   row_type;
  logic [4:0]   sx_lo;
  logic         frame_end;
  logic         cfg_xfer;
  logic         row_in_range;

  assign ah         = h_count - 10'(H_START);
  assign av         = v_count - 10'(V_START);
  assign pix_active = (ah < 10'(H_ACT)) && (av < 10'(V_ACT));
  assign pix_row    = av[8:5];
  assign row_ok     = pix_row < 4'(ROWS);
  assign row_type   = row_ok ? live_q[pix_row] : TT_NONE;

  assign frame_end    = (h_count == 10'(H_TOTAL - 1)) && (v_count == 10'(V_TOTAL - 1));
  assign cfg_xfer     = cfg_valid && cfg_ready_q;
  assign row_in_range = cfg_row < 4'(ROWS);

`ifdef BG_SCROLL_EN
  logic [4:0] speed_q  [ROWS];
  logic [9:0] offset_q [ROWS];
  logic [9:0] commit_off;
  logic [4:0] row_off_lo;

  bg_scroll_wrap #(
    .WRAP (H_ACT)
  ) u_wrap (
    .offset_i  (offset_q[idx_q]),
    .speed_i   (speed_q[idx_q]),
    .wrapped_o (commit_off)
  );

  // 640 is a multiple of the tile width, so the mod-640 wrap never changes
  // the low five bits: tile_x is just the 5-bit sum.
  assign row_off_lo = row_ok ? offset_q[pix_row][4:0] : '0;
  assign sx_lo      = ah[4:0] + row_off_lo;
`else
  logic unused_speed;
  assign unused_speed = ^cfg_speed;
  assign sx_lo        = ah[4:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      idx_q        <= '0;
      cfg_ready_q  <= 1'b1;
      frame_tick_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      for (int unsigned i = 0; i < ROWS; i++) begin
        live_q[i]   <= reset_type(i);
        shadow_q[i] <= reset_type(i);
`ifdef BG_SCROLL_EN
        speed_q[i]  <= '0;
        offset_q[i] <= '0;
`endif
      end
    end else begin
      frame_tick_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (cfg_xfer) begin
            if (row_in_range) begin
              shadow_q[cfg_row] <= cfg_type;
`ifdef BG_SCROLL_EN
              speed_q[cfg_row]  <= cfg_speed;
`endif
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
          if (frame_end) begin
            state_q     <= ST_COMMIT;
            idx_q       <= '0;
            cfg_ready_q <= 1'b0;
          end
        end
        ST_COMMIT: begin
          live_q[idx_q] <= shadow_q[idx_q];
`ifdef BG_SCROLL_EN
          offset_q[idx_q] <= commit_off;
`endif
          if (idx_q == 4'(ROWS - 1)) begin
            state_q      <= ST_RUN;
            idx_q        <= '0;
            cfg_ready_q  <= 1'b1;
            frame_tick_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      tile_type_q <= TT_NONE;
      tile_x_q    <= '0;
      tile_y_q    <= '0;
      grid_row_q  <= '0;
    end else begin
      active_q    <= pix_active;
      tile_type_q <= pix_active ? visible_type(row_type) : TT_NONE;
      tile_x_q    <= sx_lo;
      tile_y_q    <= av[4:0];
      grid_row_q  <= pix_row;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign frame_tick = frame_tick_q;
  assign cfg_err    = cfg_err_q;
  assign active     = active_q;
  assign tile_type  = tile_type_q;
  assign tile_x     = tile_x_q;
  assign tile_y     = tile_y_q;
  assign grid_row   = grid_row_q;

endmodule

// File: doc/bg_tile_scheduler.md
Name: bg_tile_scheduler

Overview:
Per-pixel scheduler for the 640x480 tiled background: 20 cols x 15 rows of 32x32 tiles.
- Holds the live row-type table and the per-row horizontal scroll offsets.
- Accepts runtime layout/speed updates through a valid/ready port and commits them atomically once per frame, during vertical blanking.
- Drives tile select and in-tile coordinates to the background sprite BRAMs and colour mux.

Parameters:
ROWS, 15, tile rows on screen
COLS, 20, tile columns on screen
H_START, 144, first active h_count (sync 96 + back porch 48)
V_START, 35, first active v_count (sync 2 + back porch 33)
H_TOTAL, 800, h_count period
V_TOTAL, 525, v_count period

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
h_count  in  10  VGA horizontal counter
v_count  in  10  VGA vertical counter
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high with cfg_valid
cfg_row  in  4  target row 0..ROWS-1
cfg_type  in  3  row tile type code
cfg_speed  in  5  signed scroll speed, px/frame (-16..+15)
tile_type  out  3  tile type for current pixel; 7 = none/black
tile_x  out  5  x within tile
tile_y  out  5  y within tile
grid_row  out  4  current tile row
active  out  1  pixel in active region
frame_tick  out  1  one-cycle pulse when commit completes
cfg_err  out  1  sticky: write to row >= ROWS seen

Behaviour:
- Reset (async assert, sync release): all outputs 0 except tile_type=7 and cfg_ready=1.
  - Live and shadow tables reset to layout: row0=4 (mono sidewalk), row1=3 (reversed one-way), rows 6,9=0 (double sidewalk), row14=1 (one-way), all others=2 (road).
  - Speeds and offsets reset to 0. FSM resets to RUN.
- Type codes: 0 double sidewalk, 1 one-way, 2 road, 3 reversed one-way, 4 mono sidewalk, 5-6 reserved (treated as 7), 7 black.
- Config port:
  - Transfer occurs when cfg_valid and cfg_ready are both high on a clock edge.
  - The transfer writes the shadow type and speed for cfg_row.
  - If cfg_row >= ROWS, the write is accepted, discarded and cfg_err is set; cfg_err clears only on reset.
  - Shadow writes never affect the live output until commit.
- FSM states RUN -> COMMIT -> RUN:
  - RUN -> COMMIT on the cycle h_count==H_TOTAL-1 and v_count==V_TOTAL-1 (always blanking).
  - COMMIT takes ROWS cycles, one row per cycle (index 0..14). Each cycle: live_type[i] <= shadow_type[i]; offset[i] <= (offset[i] + speed[i]) mod 640.
  - cfg_ready=0 throughout COMMIT.
  - Leaving COMMIT pulses frame_tick for 1 cycle, then returns to RUN.
  - A cfg_valid held during COMMIT stalls and is accepted on the first RUN cycle.
- Offset arithmetic: 10-bit unsigned, speed sign-extended. If sum >= 640, subtract 640; if sum < 0, add 640. Result always in 0..639.
- Pixel path, 1-cycle registered latency (inputs at edge n -> outputs valid after edge n+1):
  - ah = h_count - H_START, av = v_count - V_START.
  - active = ah<640 and av<480 (unsigned compare, so underflow reads as inactive).
  - grid_row = av[8:5]; tile_y = av[4:0].
  - sx = (ah + offset[grid_row]) mod 640; tile_x = sx[4:0].
  - tile_type = live_type[grid_row] when active, else 7.
- Downstream BRAMs add their own latency; the colour mux delays sync by total latency.
- Reset mid-COMMIT: partial copy abandoned, tables return to reset layout.

Optional Feature:
BG_SCROLL_EN.
- Defined: per-row offsets advance at each commit as above.
- Undefined: no offset registers or adder are built; offsets are constant 0 so tile_x = ah[4:0]; cfg_speed is ignored (accepted, not stored); COMMIT copies types only, same ROWS-cycle duration.

Decomposition:
- Package bg_pkg: tile type codes (TT_DOUBLE..TT_NONE), VGA timing constants, TILE_W=32, reset layout function/constant array.
- One sub-module: bg_scroll_wrap, a combinational mod-640 signed add, instanced once and shared by the serial commit loop.

Test Plan:
1. Reset, then scan the frame. At h=144, v=35+6*32 the next cycle gives tile_type=0, grid_row=6, tile_x=0, tile_y=0. At h=143 it gives active=0 and tile_type=7.
2. Write row 3 type=0 speed=+5 mid-frame: row 3 still shows 2 until frame_tick. The following frame shows type 0, and at ah=0 tile_x=5.
3. Row 3 speed=+5 for 128 frames: offset = 640 mod 640 = 0, so at ah=0 tile_x=0. Speed -1 from offset 0 gives offset 639 and tile_x=31.
4. Assert cfg_valid at the commit start cycle: cfg_ready low for 15 cycles, accepted the cycle after frame_tick, no write lost.
5. Write cfg_row=15: cfg_ready handshake completes, cfg_err=1, live/shadow tables unchanged.
6. Pull rst_n low at commit cycle 7: outputs go to reset values asynchronously, table equals reset layout, no frame_tick emitted.
